// File: rtl/display_scan_ctrl.sv
// Calculator display front end: debounced operand capture with
// registered sum/difference, plus blanked one-hot anode scanning.
module display_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned DEB_CYCLES   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_a,
    input  logic [3:0] sw_b,
    input  logic       load,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] AplusB,
    output logic [3:0] AminusB,
    output logic       carry,
    output logic       borrow,
    output logic [3:0] anode
);

    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DFULL = DW'(DEB_CYCLES);

    logic          sync1;
    logic          load_s;
    logic          armed;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic [1:0]    idx;
    logic          fire;
    logic          blank;
    logic [4:0]    sum;

    // Capture one edge after the count saturates, only if still held.
    assign fire  = load_s && armed && (dcnt == DFULL);
    assign sum   = {1'b0, sw_a} + {1'b0, sw_b};
    assign blank = 32'(rcnt) < BLANK_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            load_s <= 1'b0;
        end else begin
            sync1  <= load;
            load_s <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt  <= '0;
            armed <= 1'b1;
        end else begin
            if (!load_s)
                dcnt <= '0;
            else if (dcnt != DFULL)
                dcnt <= dcnt + 1'b1;
            if (fire)
                armed <= 1'b0;
            else if (!load_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A       <= 4'd0;
            B       <= 4'd0;
            AplusB  <= 4'd0;
            AminusB <= 4'd0;
            carry   <= 1'b0;
            borrow  <= 1'b0;
        end else if (fire) begin
            A       <= sw_a;
            B       <= sw_b;
            AplusB  <= sum[3:0];
            carry   <= sum[4];
            AminusB <= sw_a - sw_b;
            borrow  <= sw_a < sw_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= 2'd0;
        end else if (rcnt == RLAST) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || blank) begin
            anode <= 4'b1111;
        end else begin
            unique case (idx)
                2'd0: anode <= 4'b1110;
                2'd1: anode <= 4'b1101;
                2'd2: anode <= 4'b1011;
                2'd3: anode <= 4'b0111;
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with small refresh/debounce
// parameters, vector table for captures and hand sequences for corners.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] sw_a, sw_b;
    logic [3:0] A, B, AplusB, AminusB, anode;
    logic       carry, borrow;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  prev_an = 4'b1111;
    logic [31:0] last;

    typedef struct {
        logic [3:0] a, b, s, d;
        logic       c, br;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    display_scan_ctrl #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .DEB_CYCLES  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_a   (sw_a),
        .sw_b   (sw_b),
        .load   (load),
        .A      (A),
        .B      (B),
        .AplusB (AplusB),
        .AminusB(AminusB),
        .carry  (carry),
        .borrow (borrow),
        .anode  (anode)
    );

    function automatic logic [31:0] pk(input logic [3:0] a, b, s, d,
                                       input logic c, br);
        return {14'b0, a, b, s, d, c, br};
    endfunction

    function automatic logic [31:0] outs();
        return {14'b0, A, B, AplusB, AminusB, carry, borrow};
    endfunction

    function automatic logic [3:0] scan_exp(input int j);
        int c, i;
        c = j % 8;
        i = (j / 8) % 4;
        if (c < 2) return 4'b1111;
        return ~(4'b0001 << i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock, then the anode invariants on the settled value.
    task automatic tick();
        @(posedge clk);
        #1;
        total++;
        if ($countones(~anode) > 1 ||
            (prev_an != 4'b1111 && anode != 4'b1111 && anode != prev_an)) begin
            bad++;
            $display("FAIL anode_inv: got %b prev %b", anode, prev_an);
        end
        prev_an = anode;
    endtask

    initial begin
        logic [3:0]  p;
        logic [31:0] exp;
        int          w;

        tbl[0] = '{4'd3,  4'd3,  4'd6,  4'd0,  1'b0, 1'b0};
        tbl[1] = '{4'd15, 4'd1,  4'd0,  4'd14, 1'b1, 1'b0};
        tbl[2] = '{4'd0,  4'd15, 4'd15, 4'd1,  1'b0, 1'b1};
        tbl[3] = '{4'd7,  4'd8,  4'd15, 4'd15, 1'b0, 1'b1};
        tbl[4] = '{4'd15, 4'd15, 4'd14, 4'd0,  1'b1, 1'b0};

        rst  = 1'b1;
        load = 1'b0;
        sw_a = 4'd0;
        sw_b = 4'd0;

        repeat (3) begin
            tick();
            chk("rst_data", outs(), 32'd0);
            chk("rst_anode", 32'(anode), 32'hF);
        end
        rst = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            chk("scan", 32'(anode), 32'(scan_exp(j)));
        end

        // clean press with carry and borrow
        sw_a = 4'd9;
        sw_b = 4'd12;
        load = 1'b1;
        repeat (6) tick();
        chk("press_early", outs(), 32'd0);
        tick();
        last = pk(4'd9, 4'd12, 4'd5, 4'd13, 1'b1, 1'b1);
        chk("press", outs(), last);
        for (int k = 0; k < 50; k++) begin
            if (k == 20) sw_a = 4'd3;
            tick();
            chk("hold", outs(), last);
        end

        // bounce: 3-high / 1-low never reaches the count
        load = 1'b0;
        repeat (5) tick();
        sw_a = 4'd5;
        sw_b = 4'd5;
        for (int k = 0; k < 40; k++) begin
            load = (k % 4 != 3);
            tick();
        end
        load = 1'b0;
        repeat (4) tick();
        chk("bounce", outs(), last);

        // four samples high is one short of a capture
        load = 1'b1;
        repeat (4) tick();
        load = 1'b0;
        repeat (6) tick();
        chk("short_pulse", outs(), last);

        // five samples high is exactly enough
        load = 1'b1;
        repeat (5) tick();
        load = 1'b0;
        repeat (2) tick();
        last = pk(4'd5, 4'd5, 4'd10, 4'd0, 1'b0, 1'b0);
        chk("min_pulse", outs(), last);

        for (int v = 0; v < 5; v++) begin
            load = 1'b0;
            repeat (5) tick();
            sw_a = tbl[v].a;
            sw_b = tbl[v].b;
            load = 1'b1;
            repeat (6) tick();
            chk("tbl_early", outs(), last);
            tick();
            exp = pk(tbl[v].a, tbl[v].b, tbl[v].s, tbl[v].d,
                     tbl[v].c, tbl[v].br);
            chk("tbl", outs(), exp);
            sw_a = ~tbl[v].a;
            repeat (10) tick();
            chk("tbl_once", outs(), exp);
            last = exp;
        end

        // reset in the middle of digit 2 with a count of 2 pending
        load = 1'b0;
        repeat (5) tick();
        w = 0;
        do begin
            p = anode;
            tick();
            w++;
        end while (!(anode == 4'b1011 && p == 4'b1111) && w < 64);
        chk("wait_1011", 32'(anode), 32'hB);
        sw_a = 4'd6;
        sw_b = 4'd2;
        load = 1'b1;
        repeat (4) tick();
        chk("pre_rst_anode", 32'(anode), 32'hB);
        rst = 1'b1;
        tick();
        chk("mid_rst_anode", 32'(anode), 32'hF);
        chk("mid_rst_data", outs(), 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            chk("rescan", 32'(anode), 32'(scan_exp(j)));
            if (j == 5) chk("post_rst_early", outs(), 32'd0);
            if (j == 6)
                chk("post_rst_cap", outs(),
                    pk(4'd6, 4'd2, 4'd8, 4'd4, 1'b0, 1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Front end of the calculator display path.
- Captures operands A and B from the switches on a debounced load button press, and registers A, B, A+B and A−B.
- Generates the active-low one-hot anode scan with inter-digit blanking.
- Its outputs feed the seven-segment decoder: A, B, AplusB, AminusB and anode connect directly.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range is 2 or more.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- DEB_CYCLES, 1000000: consecutive synchronized-high cycles needed to accept a load press; legal range is 1 or more.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- sw_a  input  4  operand A switches; quasi-static and not synchronized.
- sw_b  input  4  operand B switches; quasi-static and not synchronized.
- load  input  1  raw load pushbutton; asynchronous and may bounce.
- A  output  4  captured operand A.
- B  output  4  captured operand B.
- AplusB  output  4  (A+B) mod 16.
- AminusB  output  4  (A−B) mod 16, two's complement.
- carry  output  1  carry-out of A+B.
- borrow  output  1  1 when A < B (unsigned).
- anode  output  4  active-low digit enables: bit0 = A, bit1 = B, bit2 = A+B, bit3 = A−B.

Behaviour:
- Single clock domain: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - A, B, AplusB, AminusB = 0; carry = 0; borrow = 0.
  - anode = 4'b1111.
  - Digit index = 0; refresh counter = 0; debounce counter = 0; armed = 1.
  - Synchronizer flops = 0.
- Reset mid-operation: reset overrides everything in the cycle it is sampled, including an in-progress capture.
- Load path:
  - load passes through a 2-flop synchronizer to give load_s.
  - Debounce counter: increments while load_s = 1; clears to 0 whenever load_s = 0.
  - Capture fires on the edge where the counter reaches DEB_CYCLES while armed = 1; armed clears on that edge.
  - armed sets again only when load_s = 0.
  - Holding the button produces exactly one capture.
  - Timing: let N be the first edge at which clk samples load = 1, with load held high afterwards. Outputs update at edge N+DEB_CYCLES+2.
  - Any low sample on load_s before that edge restarts the count.
- Capture edge:
  - A <= sw_a, B <= sw_b.
  - AplusB <= low 4 bits of a 5-bit sw_a+sw_b; carry <= bit 4.
  - AminusB <= (sw_a − sw_b) mod 16; borrow <= (sw_a < sw_b).
  - All six outputs update on the same edge; sw_a and sw_b are sampled at that edge.
  - Between captures all six outputs hold.
- Scan path:
  - The refresh counter counts 0..REFRESH_DIV−1, then wraps to 0.
  - At wrap the digit index advances 0→1→2→3→0.
  - The scan runs continuously from reset, independent of load.
- anode is registered, with one cycle of latency from (index, counter):
  - If counter < BLANK_CYCLES, anode = 4'b1111.
  - Otherwise index 0→1110, 1→1101, 2→1011, 3→0111.
- Hard rules:
  - anode never has more than one bit low.
  - anode never changes directly from one enabled digit to another; at least one 1111 cycle separates them whenever BLANK_CYCLES ≥ 1.
  - With BLANK_CYCLES = 0 there is no blanking, and the pattern changes directly at slot boundaries.
- Simultaneous capture and slot change: both take effect independently on the same edge; the decoder sees the new values on the current digit.

Test Plan:
(bench uses REFRESH_DIV=8, BLANK_CYCLES=2, DEB_CYCLES=4)
1. Reset behaviour:
   - Stimulus: assert rst for 3 cycles, then release.
   - Required: all outputs are 0 and anode = 1111 during reset.
   - Required after release: anode is 1111 for 2 cycles, then 1110 for 6 cycles, then 1111 ×2, then 1101 ×6, continuing through 1011 and 0111 and wrapping back to 1110. The full period is 32 cycles.
2. Clean press with carry and borrow:
   - Stimulus: sw_a=9, sw_b=12, hold load high from edge N.
   - Required at edge N+6: A=9, B=12, AplusB=5, carry=1, AminusB=13, borrow=1.
   - Required afterwards: the outputs stay stable while load is held 50 cycles. Changing sw_a to 3 without releasing load causes no change.
3. Bounce rejection:
   - Stimulus: load toggles with high runs of 3 cycles separated by 1-cycle lows for 40 cycles.
   - Required: no capture; outputs keep their previous values.
4. Re-arm and no-overflow case:
   - Stimulus: release load for 5 cycles; set sw_a=3, sw_b=3; press again.
   - Required: AplusB=6, carry=0, AminusB=0, borrow=0, captured exactly once.
5. Reset mid-operation:
   - Stimulus: assert rst while anode=1011 and while a debounce count of 2 is in progress.
   - Required on the next edge: anode=1111 and all data outputs = 0.
   - Required after release: the scan restarts at digit 0. The aborted press does not capture unless it is held a full DEB_CYCLES+2 edges after release.
6. Continuous invariant checks (assertion over the whole run):
   - Required: popcount(~anode) ≤ 1 at all times.
   - Required: no direct transition between two distinct enabled patterns.
